// File: rtl/rsa_modexp_if.sv
// Operand/result bundle for the modular-exponentiation engine.
// master drives the request side, slave is the engine.
interface rsa_modexp_if #(
    parameter int unsigned INPUTSIZE = 12
);
    logic                 start;
    logic [INPUTSIZE-1:0] base;
    logic [INPUTSIZE-1:0] exponent;
    logic [INPUTSIZE-1:0] modulus;
    logic [INPUTSIZE-1:0] result;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start, base, exponent, modulus,
        input  result, busy, done, error
    );

    modport slave (
        input  start, base, exponent, modulus,
        output result, busy, done, error
    );
endinterface

// File: rtl/rsa_modexp.sv
// Sequential modular exponentiation, result = base^exponent mod modulus,
// using right-to-left square-and-multiply with a separate reduction cycle.
module rsa_modexp #(
    parameter int unsigned INPUTSIZE = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    rsa_modexp_if.slave   bus
);
    localparam int unsigned W  = INPUTSIZE;
    localparam int unsigned PW = 2 * INPUTSIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CHECK,
        S_MUL,
        S_MRED,
        S_SQR,
        S_SRED
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    e_q, e_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    n_q, n_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [W-1:0]    result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            e_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            prod_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        e_d      = e_q;
        b_d      = b_q;
        acc_d    = acc_q;
        n_d      = n_q;
        prod_d   = prod_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    b_d     = bus.base;
                    e_d     = bus.exponent;
                    n_d     = bus.modulus;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end

            // Zero modulus is rejected; otherwise bring base into range
            S_PREP: begin
                if (n_q == '0) begin
                    result_d = '0;
                    error_d  = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    b_d     = W'(b_q % n_q);
                    acc_d   = W'(W'(1) % n_q);
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (e_q == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (e_q[0]) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_SQR;
                end
            end

            S_MUL: begin
                prod_d  = PW'(acc_q) * PW'(b_q);
                state_d = S_MRED;
            end

            S_MRED: begin
                acc_d   = W'(prod_q % PW'(n_q));
                state_d = S_SQR;
            end

            S_SQR: begin
                prod_d  = PW'(b_q) * PW'(b_q);
                state_d = S_SRED;
            end

            // Squared base reduced, then the next exponent bit moves into e_q[0]
            S_SRED: begin
                b_d     = W'(prod_q % PW'(n_q));
                e_d     = e_q >> 1;
                state_d = S_CHECK;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Self-checking bench for rsa_modexp: cycle-level reference model plus
// directed vectors with hand-computed results and done edges.
`timescale 1ns/1ps
module tb_rsa_modexp;
    localparam int unsigned W = 12;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rsa_modexp_if #(.INPUTSIZE(W)) bus ();

    rsa_modexp #(.INPUTSIZE(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain repeated multiplication, no bit scanning
    function automatic int ref_pow(input int b, input int e, input int n);
        int r;
        if (n == 0) return 0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    // Done edge relative to the accept edge
    function automatic int ref_lat(input int e, input int n);
        int k;
        int p;
        if (n == 0) return 1;
        k = 0;
        p = 0;
        for (int i = 0; i < W; i++) begin
            if (((e >> i) & 1) != 0) begin
                k = i + 1;
                p++;
            end
        end
        return 2 + 3 * k + 2 * p;
    endfunction

    // Transaction-level model of the outputs
    bit m_busy, m_done, m_err;
    int m_res, m_left, m_pend_res;
    bit m_pend_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_res = 0; m_left = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy     = 1;
                m_done     = 0;
                m_err      = 0;
                m_left     = ref_lat(int'(bus.exponent), int'(bus.modulus));
                m_pend_res = ref_pow(int'(bus.base), int'(bus.exponent), int'(bus.modulus));
                m_pend_err = (bus.modulus == '0);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
                m_res  = m_pend_res;
                m_err  = m_pend_err;
            end
        end
    end

    // Compare every cycle; result is only meaningful outside an operation
    always @(negedge clk) begin
        chk("busy", int'(bus.busy), int'(m_busy));
        chk("done", int'(bus.done), int'(m_done));
        chk("error", int'(bus.error), int'(m_err));
        if (!m_busy) chk("result", int'(bus.result), m_res);
    end

    // Waits for done after the accept edge; optional stray start pulses at edges 3 and 10
    task automatic wait_done(input bit pulse, output int edge_n, output bit seen);
        seen   = 0;
        edge_n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            edge_n = i;
            if (bus.done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            if (pulse) begin
                bus.start    = (i + 1 == 3) || (i + 1 == 10);
                bus.base     = W'($urandom);
                bus.exponent = W'($urandom);
                bus.modulus  = W'($urandom_range(2, 4095));
            end
        end
    endtask

    task automatic run_op(input string tag, input int b, input int e, input int m,
                          input int exp_res, input int exp_edge, input int exp_err,
                          input bit pulse);
        int  edge_n;
        bit  seen;
        @(negedge clk);
        bus.base     = W'(b);
        bus.exponent = W'(e);
        bus.modulus  = W'(m);
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.base     = W'($urandom);
        bus.exponent = W'($urandom);
        bus.modulus  = W'($urandom);
        wait_done(pulse, edge_n, seen);
        bus.start = 1'b0;
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_edge"}, edge_n, exp_edge);
        chk({tag, "_result"}, int'(bus.result), exp_res);
        chk({tag, "_error"}, int'(bus.error), exp_err);
    endtask

    initial begin
        int  edge_n;
        bit  seen;
        int  rb, re, rm;
        checks = 0;
        errors = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;

        chk("pin_model_pow", ref_pow(4, 13, 497), 445);
        chk("pin_model_enc", ref_pow(65, 17, 3233), 2790);
        chk("pin_model_lat", ref_lat(2753, 3233), 48);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", int'(bus.result), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_error", int'(bus.error), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 4, 13, 497, 445, 20, 0, 0);
        run_op("encrypt", 65, 17, 3233, 2790, 21, 0, 0);
        run_op("decrypt", 2790, 2753, 3233, 65, 48, 0, 0);
        run_op("exp_zero", 5, 0, 7, 1, 2, 0, 0);
        run_op("mod_one", 7, 5, 1, 0, 15, 0, 0);
        run_op("mod_zero", 9, 5, 0, 0, 1, 1, 0);
        run_op("base_big", 4000, 1, 3233, 767, 7, 0, 0);
        run_op("base_zero", 0, 6, 11, 0, 15, 0, 0);
        run_op("ignore_start", 4, 13, 497, 445, 20, 0, 1);

        // start held high through completion: back-to-back with same operands
        @(negedge clk);
        bus.base = W'(65); bus.exponent = W'(17); bus.modulus = W'(3233);
        bus.start = 1'b1;
        @(posedge clk);
        wait_done(0, edge_n, seen);
        chk("hold_first_seen", int'(seen), 1);
        chk("hold_first_edge", edge_n, 21);
        chk("hold_first_result", int'(bus.result), 2790);
        @(posedge clk);
        #1;
        chk("hold_done_drop", int'(bus.done), 0);
        chk("hold_busy_again", int'(bus.busy), 1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(0, edge_n, seen);
        chk("hold_second_seen", int'(seen), 1);
        chk("hold_second_edge", edge_n, 21);
        chk("hold_second_result", int'(bus.result), 2790);

        // Reset at edge 15 of a decrypt
        @(negedge clk);
        bus.base = W'(2790); bus.exponent = W'(2753); bus.modulus = W'(3233);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_result", int'(bus.result), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 2, 10, 1000, 24, 18, 0, 0);

        for (int t = 0; t < 500; t++) begin
            rb = $urandom_range(0, 4095);
            re = $urandom_range(0, 4095);
            rm = $urandom_range(2, 4095);
            run_op("sweep", rb, re, rm, ref_pow(rb, re, rm), ref_lat(re, rm), 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rsa_modexp.md
# rsa_modexp

Sequential modular-exponentiation engine computing result = base^exponent mod modulus by right-to-left square-and-multiply. It is the consumer of the key pair: it decrypts with the private exponent d and encrypts with the public exponent e. One start/done transaction per operation; operands are captured at start.

## Interface
- INPUTSIZE, 12, width of base, exponent, modulus and result
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- base  input  INPUTSIZE  message or ciphertext; any value, including base >= modulus
- exponent  input  INPUTSIZE  e (encrypt) or d (decrypt)
- modulus  input  INPUTSIZE  n
- result  output  INPUTSIZE  registered result; valid while done=1
- busy  output  1  high from the accept edge until the done edge
- done  output  1  level flag; held high until the next accepted start
- error  output  1  set with done when modulus == 0

## Operation
- Internal registers:
  - e_r: shifting exponent, INPUTSIZE bits
  - b_r: running base, INPUTSIZE bits
  - acc_r: accumulator, INPUTSIZE bits
  - n_r: modulus copy
  - prod_r: product, 2*INPUTSIZE bits
- All products are computed into prod_r at full 2*INPUTSIZE width. The % reduction by n_r is done in a separate cycle. No truncation before reduction.
- States: IDLE, PREP, CHECK, MUL, MRED, SQR, SRED.
- IDLE:
  - On start=1, capture base, exponent and modulus.
  - Clear done and error, set busy, go to PREP.
  - start while busy is ignored.
- PREP:
  - If n_r == 0: result=0, error=1, done=1, busy=0, go to IDLE.
  - Otherwise b_r = base % n_r and acc_r = 1 % n_r. For n_r == 1 this gives 0. Go to CHECK.
- CHECK:
  - If e_r == 0: result=acc_r, done=1, busy=0, go to IDLE.
  - Else if e_r[0] == 1: go to MUL.
  - Else: go to SQR.
- MUL: prod_r = acc_r * b_r, then MRED.
- MRED: acc_r = prod_r % n_r, then SQR.
- SQR: prod_r = b_r * b_r, then SRED.
- SRED: b_r = prod_r % n_r, e_r = e_r >> 1, then CHECK.
- Boundary cases:
  - exponent 0 gives result = 1 % modulus.
  - base 0 with exponent > 0 gives 0.
  - base >= modulus is reduced in PREP.
- Inputs may change freely after the accept edge without affecting the operation in flight.

## Timing
- Reset values: result=0, busy=0, done=0, error=0, state IDLE, all internal registers 0.
- Reset asserted mid-operation aborts immediately. No done pulse follows.
- Notation: edge 0 is the edge that accepts start; k is the bit length of exponent (index of MSB + 1); p is the popcount of exponent.
- done, result and busy=0 update together on edge 2 + 3k + 2p.
- Each exponent bit costs 3 cycles if it is 0 and 5 cycles if it is 1.
- exponent == 0 gives done at edge 2. modulus == 0 gives done and error at edge 1.
- Maximum latency for INPUTSIZE=12 is 62 cycles (exponent all ones).
- start held high continuously:
  - It is accepted on the first IDLE edge after done.
  - done drops on that edge, so done is high for exactly 1 cycle between back-to-back operations.
- done and result remain stable while in IDLE with start low.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → result=0, busy=0, done=0, error=0. Release, then start with base=4, exponent=13, modulus=497 → result=445 at edge 20, busy high for edges 0..19.
- RSA round trip with n=3233, e=17, d=2753:
  - base=65, exponent=17 → result=2790 at edge 21.
  - Then base=2790, exponent=2753 → result=65 at edge 48.
- Boundaries:
  - base=5, exponent=0, modulus=7 → result=1 at edge 2.
  - modulus=1 → result=0.
  - modulus=0 → error=1 and done at edge 1.
  - base=4000, exponent=1, modulus=3233 → result=767.
- Protocol:
  - Pulse start again at edges 3 and 10 of a running operation, with different operands → ignored; result matches the first operand set.
  - Hold start high across completion → next operation accepted immediately and done high for exactly 1 cycle.
- Reset mid-operation: assert rst_n=0 at edge 15 of the 2790^2753 decrypt → busy, done and result clear asynchronously. After release, a new start (base=2, exponent=10, modulus=1000) → result=24.
- Randomized sweep over 500 random (base, exponent, modulus ≥ 2) triples against a reference model → result matches and latency equals 2 + 3k + 2p for every triple.
